// File: rtl/hall_tachometer.sv
// hall_tachometer: decodes the three hall inputs into signed position,
// direction, commutation period, stall flag and fault count, and presents a
// snapshot of them through a single-cycle request/acknowledge handshake.
// Optional glitch filter between the synchronizer and the decoder is enabled
// by defining HALL_TACHOMETER_FILTER_EN.
module hall_tachometer #(
  parameter int COUNT_WIDTH   = 16,
  parameter int PERIOD_WIDTH  = 16,
  parameter int FAULT_WIDTH   = 8,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              h,
  input  logic                    sample_req,
  output logic                    sample_ack,
  output logic [COUNT_WIDTH-1:0]  position,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    direction,
  output logic                    stalled,
  output logic [FAULT_WIDTH-1:0]  fault_count
);

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_filter
    $error("hall_tachometer: FILTER_CYCLES must be in 1..15");
  end

  localparam logic [2:0] IDX_BAD = 3'd7;

  // Forward commutation order 001,011,010,110,100,101 -> 0..5.
  function automatic logic [2:0] hall_idx(input logic [2:0] code);
    case (code)
      3'b001:  hall_idx = 3'd0;
      3'b011:  hall_idx = 3'd1;
      3'b010:  hall_idx = 3'd2;
      3'b110:  hall_idx = 3'd3;
      3'b100:  hall_idx = 3'd4;
      3'b101:  hall_idx = 3'd5;
      default: hall_idx = IDX_BAD;
    endcase
  endfunction

  logic [2:0]              h_meta_q, h_sync_q, code_w, h_last_q;
  logic                    locked_q;
  logic [2:0]              prev_idx_q;
  logic [COUNT_WIDTH-1:0]  pos_q;
  logic                    dir_q;
  logic [PERIOD_WIDTH-1:0] per_cnt_q, per_q;
  logic                    stall_q;
  logic [FAULT_WIDTH-1:0]  fault_q, fault_d, fault_base;
  logic                    sample_pend_q, ack_q;
  logic [COUNT_WIDTH-1:0]  snap_pos_q;
  logic [PERIOD_WIDTH-1:0] snap_per_q;
  logic                    snap_dir_q, snap_stall_q;
  logic [FAULT_WIDTH-1:0]  snap_fault_q;

  logic [2:0] new_idx, delta;
  logic       code_chg, code_ok, live;
  logic       lock_evt, step_fwd, step_rev, skip_evt, bad_evt, step_evt, per_sat;

  // Two-flop synchronizer for the asynchronous hall inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_meta_q <= '0;
      h_sync_q <= '0;
    end else begin
      h_meta_q <= h;
      h_sync_q <= h_meta_q;
    end
  end

`ifdef HALL_TACHOMETER_FILTER_EN
  localparam logic [3:0] FILT_N = 4'(FILTER_CYCLES);

  logic [2:0] h_cand_q, h_filt_q;
  logic [3:0] filt_cnt_q;

  // Accept a new synchronized code only after FILT_N consecutive samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cand_q   <= '0;
      h_filt_q   <= '0;
      filt_cnt_q <= '0;
    end else if (h_sync_q == h_filt_q) begin
      h_cand_q   <= h_sync_q;
      filt_cnt_q <= '0;
    end else if (h_sync_q != h_cand_q) begin
      h_cand_q   <= h_sync_q;
      filt_cnt_q <= 4'd1;
      if (FILT_N == 4'd1) h_filt_q <= h_sync_q;
    end else if ((filt_cnt_q + 4'd1) >= FILT_N) begin
      h_filt_q   <= h_sync_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 4'd1;
    end
  end

  assign code_w = h_filt_q;
`else
  assign code_w = h_sync_q;
`endif

  // Classify each change of the decoded code against the held index.
  always_comb begin
    new_idx  = hall_idx(code_w);
    code_chg = (code_w != h_last_q);
    code_ok  = (new_idx != IDX_BAD);
    // Modulo-6 distance; the 3-bit wrap is harmless since the result is 1..5.
    if (new_idx >= prev_idx_q) delta = new_idx - prev_idx_q;
    else                       delta = new_idx + 3'd6 - prev_idx_q;
    live     = code_chg && locked_q;
    lock_evt = code_chg && !locked_q && code_ok;
    step_fwd = live && code_ok && (delta == 3'd1);
    step_rev = live && code_ok && (delta == 3'd5);
    skip_evt = live && code_ok && (delta == 3'd2 || delta == 3'd3 || delta == 3'd4);
    bad_evt  = live && !code_ok;
    step_evt = step_fwd || step_rev;
    per_sat  = (per_cnt_q == '1);
    // A snapshot clears the count, but a fault on that same edge survives.
    fault_base = sample_pend_q ? '0 : fault_q;
    fault_d    = fault_base;
    if ((skip_evt || bad_evt) && (fault_base != '1))
      fault_d = fault_base + FAULT_WIDTH'(1);
  end

  // Position, direction, period and fault tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_last_q   <= '0;
      locked_q   <= 1'b0;
      prev_idx_q <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      per_cnt_q  <= '1;
      per_q      <= '1;
      stall_q    <= 1'b1;
      fault_q    <= '0;
    end else begin
      h_last_q <= code_w;
      fault_q  <= fault_d;
      if (lock_evt) locked_q <= 1'b1;
      if (lock_evt || step_evt || skip_evt) prev_idx_q <= new_idx;
      if (step_fwd) begin
        pos_q <= pos_q + COUNT_WIDTH'(1);
        dir_q <= 1'b1;
      end else if (step_rev) begin
        pos_q <= pos_q - COUNT_WIDTH'(1);
        dir_q <= 1'b0;
      end
      if (step_evt) begin
        per_q   <= per_cnt_q;
        stall_q <= 1'b0;
      end else if (per_sat) begin
        per_q   <= '1;
        stall_q <= 1'b1;
      end
      // Restart at 1 so the latched value equals edges between steps.
      if (lock_evt || step_evt) per_cnt_q <= PERIOD_WIDTH'(1);
      else if (!per_sat)        per_cnt_q <= per_cnt_q + PERIOD_WIDTH'(1);
    end
  end

  // Snapshot handshake: load the outputs one edge after the request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_pend_q <= 1'b0;
      ack_q         <= 1'b0;
      snap_pos_q    <= '0;
      snap_per_q    <= '1;
      snap_dir_q    <= 1'b0;
      snap_stall_q  <= 1'b1;
      snap_fault_q  <= '0;
    end else begin
      sample_pend_q <= sample_req;
      ack_q         <= sample_pend_q;
      if (sample_pend_q) begin
        snap_pos_q   <= pos_q;
        snap_per_q   <= per_q;
        snap_dir_q   <= dir_q;
        snap_stall_q <= stall_q;
        snap_fault_q <= fault_q;
      end
    end
  end

  assign sample_ack  = ack_q;
  assign position    = snap_pos_q;
  assign period      = snap_per_q;
  assign direction   = snap_dir_q;
  assign stalled     = snap_stall_q;
  assign fault_count = snap_fault_q;

endmodule
